// File: rtl/miss_vote_decoder.sv
// Threshold-vote decoder: every PROBES_PER_BIT accepted probe results become one
// channel bit ("1" when enough probes missed), assembled LSB-first into out_data.
module miss_vote_decoder #(
  parameter int STR_LEN        = 16,
  parameter int PROBES_PER_BIT = 4,
  parameter int MISS_THRESH    = 2,
  parameter int CNT_W          = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       probe_valid,
  input  logic                       probe_hit,
  input  logic                       stall,
  output logic                       busy,
  output logic                       bit_valid,
  output logic                       bit_out,
  output logic [$clog2(STR_LEN)-1:0] bit_idx,
  output logic [STR_LEN-1:0]         out_data,
  output logic                       done
);

  localparam int IDX_W = $clog2(STR_LEN);
  localparam logic [CNT_W-1:0] LAST_PROBE = CNT_W'(PROBES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(MISS_THRESH);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(STR_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] probe_cnt, miss_cnt;
  logic [CNT_W-1:0] miss_next;
  logic             accept, window_end, vote;

  // Vote includes the probe being accepted this cycle, so no extra decision cycle.
  assign accept     = (state == S_COLLECT) && probe_valid && !stall;
  assign window_end = accept && (probe_cnt == LAST_PROBE);
  assign miss_next  = miss_cnt + CNT_W'(!probe_hit);
  assign vote       = (miss_next >= THRESH);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_COLLECT;
      S_COLLECT:      if (window_end && (bit_idx == LAST_IDX)) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_COLLECT);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      probe_cnt <= '0;
      miss_cnt  <= '0;
      bit_idx   <= '0;
      out_data  <= '0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            probe_cnt <= '0;
            miss_cnt  <= '0;
            bit_idx   <= '0;
            out_data  <= '0;
          end
        end
        S_COLLECT: begin
          if (window_end) begin
            out_data[bit_idx] <= vote;
            bit_out           <= vote;
            bit_valid         <= 1'b1;
            probe_cnt         <= '0;
            miss_cnt          <= '0;
            if (bit_idx != LAST_IDX) bit_idx <= bit_idx + 1'b1;
          end else if (accept) begin
            probe_cnt <= probe_cnt + 1'b1;
            miss_cnt  <= miss_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miss_vote_decoder.sv
// Bench for miss_vote_decoder: probe-list reference model feeding a scoreboard of
// expected bit decisions, checked by a negedge monitor.
module tb_miss_vote_decoder;
  localparam int STR_LEN = 16;
  localparam int PPB     = 4;
  localparam int TH      = 2;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = $clog2(STR_LEN);

  logic               clk = 1'b0;
  logic               rst, start, probe_valid, probe_hit, stall;
  logic               busy, bit_valid, bit_out, done;
  logic [IDX_W-1:0]   bit_idx;
  logic [STR_LEN-1:0] out_data;

  miss_vote_decoder #(.STR_LEN(STR_LEN), .PROBES_PER_BIT(PPB), .MISS_THRESH(TH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .probe_valid(probe_valid), .probe_hit(probe_hit),
    .stall(stall), .busy(busy), .bit_valid(bit_valid), .bit_out(bit_out), .bit_idx(bit_idx),
    .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=collect 2=done; window holds miss flags of accepted probes.
  int                 m_mode = 0;
  bit                 m_win[$];
  int                 m_k = 0;
  logic [STR_LEN-1:0] m_data = '0;
  bit                 m_exp[$];
  bit                 mon_en = 1'b0;

  task automatic model(bit r, bit s, bit pv, bit ph, bit st);
    int misses;
    bit b;
    if (r) begin
      m_mode = 0; m_k = 0; m_data = '0; m_win.delete();
    end else if (m_mode != 1) begin
      if (s) begin
        m_mode = 1; m_k = 0; m_data = '0; m_win.delete();
      end
    end else if (pv && !st) begin
      m_win.push_back(!ph);
      if (m_win.size() == PPB) begin
        misses = 0;
        foreach (m_win[i]) misses += int'(m_win[i]);
        b = (misses >= TH);
        m_data[m_k] = b;
        m_exp.push_back(b);
        m_k++;
        m_win.delete();
        if (m_k == STR_LEN) m_mode = 2;
      end
    end
  endtask

  task automatic cyc(bit r, bit s, bit pv, bit ph, bit st);
    rst = r; start = s; probe_valid = pv; probe_hit = ph; stall = st;
    @(posedge clk);
    model(r, s, pv, ph, st);
    #1;
  endtask

  function automatic int model_idx();
    return (m_k >= STR_LEN) ? STR_LEN - 1 : m_k;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, m_mode == 1);
      chk("done", done, m_mode == 2);
      chk("bit_idx", bit_idx, model_idx());
      chk("out_data", out_data, m_data);
      if (bit_valid) begin
        if (m_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bit_valid: got 1 expected 0 (bit_out=%0b)", bit_out);
        end else begin
          chk("bit_out", bit_out, m_exp.pop_front());
        end
      end else if (m_exp.size() != 0) begin
        checks++; errors++;
        $display("FAIL missing_bit_valid: got 0 expected 1 (%0d pending)", m_exp.size());
        m_exp.delete();
      end
    end
  end

  // One window of PPB accepted probes with the given number of misses at random positions.
  task automatic send_window(int misses, bit gaps);
    bit a[PPB];
    bit t;
    int j;
    for (int i = 0; i < PPB; i++) a[i] = (i < misses);
    for (int i = PPB - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    for (int i = 0; i < PPB; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) cyc(0, 0, 1, 1'($urandom_range(0, 1)), 1);
        else                           cyc(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      cyc(0, 0, 1, !a[i], 0);
    end
  endtask

  task automatic send_bit(bit b, bit gaps);
    send_window(b ? (TH + $urandom_range(0, PPB - TH)) : $urandom_range(0, TH - 1), gaps);
  endtask

  logic [STR_LEN-1:0] pattern;

  initial begin
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 0);
    mon_en = 1'b1;
    cyc(0, 0, 1, 0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bit_valid", bit_valid, 0);
    chk("reset_bit_out", bit_out, 0);
    chk("reset_out_data", out_data, 0);

    // All-miss transfer.
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < STR_LEN * PPB; i++) cyc(0, 0, 1, 0, 0);
    chk("allmiss_out_data", out_data, 16'hFFFF);
    chk("allmiss_done", done, 1);
    cyc(0, 0, 1, 0, 0);
    chk("done_holds_data", out_data, 16'hFFFF);

    // Pattern transfer: 3 misses for "1", none for "0", with stalls and gaps.
    pattern = 16'b0101101000101001;
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < STR_LEN; i++) send_window(pattern[i] ? 3 : 0, 1);
    chk("pattern_out_data", out_data, pattern);
    chk("pattern_done", done, 1);

    // Threshold edge.
    cyc(0, 1, 0, 1, 0);
    chk("thresh_idx0", bit_idx, 0);
    send_window(TH, 0);
    chk("thresh_bit1", bit_out, 1);
    chk("thresh_idx1", bit_idx, 1);
    send_window(TH - 1, 0);
    chk("thresh_bit0", bit_out, 0);
    chk("thresh_idx2", bit_idx, 2);
    chk("thresh_data", out_data[1:0], 2'b01);

    // Stalled probes are never accepted.
    for (int i = 0; i < PPB; i++) cyc(0, 0, 1, 0, 1);
    chk("stall_idx", bit_idx, 2);
    for (int i = 0; i < PPB; i++) cyc(0, 0, 1, 0, 0);
    chk("after_stall_bit", bit_out, 1);
    chk("after_stall_idx", bit_idx, 3);

    // Reset mid-transfer after 5 bits plus 2 probes.
    cyc(1, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_idx", bit_idx, 0);
    chk("midrst_busy", busy, 0);
    for (int i = 0; i < PPB; i++) cyc(0, 0, 1, 0, 0);
    chk("midrst_idle_ignores", busy, 0);

    // Fresh transfer with start pulsed during bit 3.
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1);
    cyc(0, 1, 1, 0, 0);
    for (int i = 1; i < PPB; i++) cyc(0, 0, 1, 1, 0);
    chk("start_busy_ignored_idx", bit_idx, 4);
    for (int i = 4; i < STR_LEN; i++) send_bit(1'($urandom_range(0, 1)), 1);
    chk("fresh_done", done, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 0);
    chk("restart_cleared", out_data, 0);
    chk("restart_done_low", done, 0);

    // Fully random traffic, including random start pulses and rare resets.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));

    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("scoreboard_drained", m_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
